// File: rtl/uart_pkg.sv
// Shared types and frame geometry for the UART transmit sequencer.
// Define UART_TX_PARITY_EN to add an even-parity bit ahead of the stop bit.
package uart_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [3:0] SLC_IDLE  = 4'hF;
    localparam logic       START_BIT = 1'b0;
    localparam logic       STOP_BIT  = 1'b1;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_W  = 11;
    localparam int LAST_IDX = 10;
`else
    localparam int FRAME_W  = 10;
    localparam int LAST_IDX = 9;
`endif

    // Frame bits are transmitted from index 0 upward, so the start bit sits in the LSB.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data);
`ifdef UART_TX_PARITY_EN
        return {STOP_BIT, ^data, data, START_BIT};
`else
        return {STOP_BIT, data, START_BIT};
`endif
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-period counter: ticks on the last clock of each serial bit while enabled.
// Held at zero whenever disabled so every frame starts on a fresh bit period.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST_CNT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: latches a byte into a frame and walks the mux select across it.
// Define UART_TX_PARITY_EN to build 11-bit frames with even parity.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int SLC_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic [FRAME_W-1:0]   frame,
    output logic [SLC_W-1:0]     mux_slc,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [SLC_W-1:0] SLC_IDLE_W = SLC_W'(SLC_IDLE);
    localparam logic [SLC_W-1:0] LAST_SLC   = SLC_W'(LAST_IDX);

    state_t               state;
    state_t               state_next;
    logic [FRAME_W-1:0]   frame_next;
    logic [SLC_W-1:0]     slc_next;
    logic                 busy_next;
    logic                 done_next;
    logic                 baud_en;
    logic                 baud_tick;

    assign baud_en = (state == SEND);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk (clk),
        .rst (rst),
        .en  (baud_en),
        .tick(baud_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            frame   <= '1;
            mux_slc <= SLC_IDLE_W;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_next;
            frame   <= frame_next;
            mux_slc <= slc_next;
            tx_busy <= busy_next;
            tx_done <= done_next;
        end
    end

    // The done cycle is already IDLE, so a start held across it is accepted with one idle-high gap.
    always_comb begin
        state_next = state;
        frame_next = frame;
        slc_next   = mux_slc;
        busy_next  = tx_busy;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                slc_next  = SLC_IDLE_W;
                busy_next = 1'b0;
                if (tx_start) begin
                    frame_next = build_frame(tx_data);
                    slc_next   = '0;
                    busy_next  = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (baud_tick) begin
                    if (mux_slc < LAST_SLC) begin
                        slc_next = mux_slc + SLC_W'(1);
                    end else begin
                        slc_next   = SLC_IDLE_W;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl against a cycle-count model of the serial frame.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame variant.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = FRAME_W * CPB;

`ifdef UART_TX_PARITY_EN
    localparam logic [FRAME_W-1:0] LIT_RESET = 11'h7FF;
    localparam logic [FRAME_W-1:0] LIT_A5    = 11'h54A;
    localparam logic [FRAME_W-1:0] LIT_00    = 11'h400;
    localparam logic [FRAME_W-1:0] LIT_FF    = 11'h5FE;
    localparam int                 LIT_LAT   = 44;
`else
    localparam logic [FRAME_W-1:0] LIT_RESET = 10'h3FF;
    localparam logic [FRAME_W-1:0] LIT_A5    = 10'h34A;
    localparam logic [FRAME_W-1:0] LIT_00    = 10'h200;
    localparam logic [FRAME_W-1:0] LIT_FF    = 10'h3FE;
    localparam int                 LIT_LAT   = 40;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic [FRAME_W-1:0] frame;
    logic [3:0]         mux_slc;
    logic               tx_busy;
    logic               tx_done;

    int checks = 0;
    int errors = 0;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .frame   (frame),
        .mux_slc (mux_slc),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    // Reference: a frame is FRAME_CYC cycles long; the select is elapsed time divided by bit length.
    bit                 m_valid = 1'b0;
    bit                 m_active = 1'b0;
    bit                 m_done = 1'b0;
    int                 m_elapsed = 0;
    logic [FRAME_W-1:0] m_frame = '1;

    function automatic logic [FRAME_W-1:0] model_frame(input logic [7:0] d);
        int value;
        int par;
        par   = $countones(d) % 2;
        value = (1 << (FRAME_W - 1)) + (int'(d) * 2);
        if (FRAME_W == 11) value = value + par * 512;
        return FRAME_W'(value);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid   <= 1'b1;
            m_active  <= 1'b0;
            m_done    <= 1'b0;
            m_elapsed <= 0;
            m_frame   <= '1;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (m_elapsed == FRAME_CYC - 1) begin
                    m_active  <= 1'b0;
                    m_done    <= 1'b1;
                    m_elapsed <= 0;
                end else begin
                    m_elapsed <= m_elapsed + 1;
                end
            end else if (tx_start) begin
                m_active  <= 1'b1;
                m_elapsed <= 0;
                m_frame   <= model_frame(tx_data);
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check_output("frame", 32'(frame), 32'(m_frame));
            check_output("mux_slc", 32'(mux_slc), m_active ? 32'(m_elapsed / CPB) : 32'd15);
            check_output("tx_busy", 32'(tx_busy), 32'(m_active));
            check_output("tx_done", 32'(tx_done), 32'(m_done));
        end
    end

    task automatic apply_stimulus(input logic s, input logic [7:0] d);
        @(negedge clk);
        tx_start = s;
        tx_data  = d;
    endtask

    task automatic wait_slc(input logic [3:0] v, input string name);
        int n;
        n = 0;
        while (mux_slc !== v && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (mux_slc !== v) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: timeout waiting for mux_slc=%0h, got %0h", name, v, mux_slc);
        end
    endtask

    task automatic wait_done(input string name, output int cycles, output int busy_cycles, output int max_slc);
        cycles      = 0;
        busy_cycles = tx_busy ? 1 : 0;
        max_slc     = (mux_slc != 4'hF) ? int'(mux_slc) : 0;
        do begin
            @(negedge clk);
            cycles++;
            if (tx_busy) busy_cycles++;
            if (mux_slc != 4'hF && int'(mux_slc) > max_slc) max_slc = int'(mux_slc);
        end while (!tx_done && cycles < 1000);
        if (!tx_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: timeout waiting for tx_done, got 0 expected 1", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int busy_n;
        int max_slc;
        int done_n;
        int idle_n;

        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset asserted in the middle of a frame
        apply_stimulus(1'b1, 8'h5A);
        apply_stimulus(1'b0, 8'h00);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("reset_slc", 32'(mux_slc), 32'hF);
        check_output("reset_busy", 32'(tx_busy), 32'h0);
        check_output("reset_done", 32'(tx_done), 32'h0);
        check_output("reset_frame", 32'(frame), 32'(LIT_RESET));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte 8'hA5
        apply_stimulus(1'b1, 8'hA5);
        apply_stimulus(1'b0, 8'h00);
        check_output("single_first_slc", 32'(mux_slc), 32'h0);
        check_output("single_frame", 32'(frame), 32'(LIT_A5));
        check_output("model_frame_a5", 32'(model_frame(8'hA5)), 32'(LIT_A5));
        wait_done("single", lat, busy_n, max_slc);
        check_output("single_latency", 32'(lat), 32'(LIT_LAT));
        check_output("single_busy_len", 32'(busy_n), 32'(LIT_LAT));
        check_output("single_max_slc", 32'(max_slc), 32'(LAST_IDX));
        repeat (3) @(negedge clk);

        // Start while busy must be ignored
        apply_stimulus(1'b1, 8'hA5);
        apply_stimulus(1'b0, 8'h00);
        wait_slc(4'h5, "busy_reach5");
        apply_stimulus(1'b1, 8'h3C);
        apply_stimulus(1'b0, 8'h00);
        done_n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_done) done_n++;
        end
        check_output("busy_frame", 32'(frame), 32'(LIT_A5));
        check_output("busy_done_count", 32'(done_n), 32'h1);

        // Back-to-back with tx_start held high
        apply_stimulus(1'b1, 8'h00);
        apply_stimulus(1'b1, 8'hFF);
        check_output("b2b_frame0", 32'(frame), 32'(LIT_00));
        check_output("model_frame_00", 32'(model_frame(8'h00)), 32'(LIT_00));
        wait_done("b2b_first", lat, busy_n, max_slc);
        idle_n = 0;
        while (mux_slc == 4'hF && idle_n < 10) begin
            idle_n++;
            @(negedge clk);
        end
        check_output("b2b_idle_gap", 32'(idle_n), 32'h1);
        check_output("b2b_frame1", 32'(frame), 32'(LIT_FF));
        tx_start = 1'b0;
        wait_done("b2b_second", lat, busy_n, max_slc);
        repeat (2) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        apply_stimulus(1'b1, 8'h07);
        apply_stimulus(1'b0, 8'h00);
        check_output("parity_frame_07", 32'(frame), 32'h60E);
        wait_done("parity_07", lat, busy_n, max_slc);
        check_output("parity_latency", 32'(lat), 32'd44);
        check_output("parity_max_slc", 32'(max_slc), 32'd10);
        apply_stimulus(1'b1, 8'h03);
        apply_stimulus(1'b0, 8'h00);
        check_output("parity_frame_03", 32'(frame), 32'h406);
        wait_done("parity_03", lat, busy_n, max_slc);
        repeat (2) @(negedge clk);
`endif

        // Randomized traffic with occasional resets; the compare process does the checking
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            tx_start = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst      = 1'b0;
        tx_start = 1'b0;
        repeat (FRAME_CYC + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
